instr_fetch: RTL

Instruction fetch unit for the single-issue RV32 core. It generates the program counter, reads instruction words from instruction memory, and delivers them with their PC to the main control decoder through a valid/ready handshake. Branch and jump redirects from execute flush buffered and in-flight instructions. It sits between instruction memory and the control/decode stage, and is the producer side of the `instruction` input the decoder consumes.

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/instr_fetch.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the RV32 instruction fetch unit.
// Optional feature macro used by instr_fetch: FETCH_OPCODE_CHECK_EN.
package fetch_pkg;

   // Instruction and address width of the core.
   localparam int ILEN = 32;

   // Fetch control states:
   //   FETCH : nothing outstanding, may issue a request
   //   WAIT  : one request outstanding, its response will be kept
   //   DROP  : one request outstanding, its response is stale and discarded
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      DROP  = 2'd2
   } fetch_state_t;

   // Major opcodes the decoder supports.
   localparam logic [6:0] OPC_RTYPE  = 7'd51;
   localparam logic [6:0] OPC_LOAD   = 7'd3;
   localparam logic [6:0] OPC_STORE  = 7'd35;
   localparam logic [6:0] OPC_BRANCH = 7'd99;

   // True when the opcode field belongs to the decoder's supported set.
   function automatic logic is_supported_opcode(input logic [6:0] opc);
      return (opc == OPC_RTYPE) || (opc == OPC_LOAD) ||
             (opc == OPC_STORE) || (opc == OPC_BRANCH);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: two-entry output queue of fetched words.
// Flush wins over push and pop; push into a full queue and pop from an empty
// queue are ignored so the occupancy count can never wrap.
module fetch_fifo #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic [1:0]   count,
   output logic [W-1:0] head
);

   logic [W-1:0] r_mem [0:1];
   logic         r_rd_ptr;
   logic         r_wr_ptr;
   logic [1:0]   r_count;

   logic         w_push_ok;
   logic         w_pop_ok;

   // Protect the storage against over/underflow.
   always_comb begin
      w_push_ok = push && (r_count != 2'd2);
      w_pop_ok  = pop  && (r_count != 2'd0);
   end

   // Storage, pointers and occupancy; flush empties the queue in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (flush) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // The head entry drives the consumer directly; a push never lands on the
   // head slot while the queue is non-empty, so the head stays stable.
   always_comb begin
      count = r_count;
      head  = r_mem[r_rd_ptr];
   end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC generation, single-outstanding instruction memory fetch and
// a two-entry valid/ready output queue feeding the decoder.
// Optional feature: define FETCH_OPCODE_CHECK_EN to add the instr_illegal
// output, computed from the opcode when a word is pushed.
//
// Handshake: instr_valid/instr_ready. A transfer happens in any cycle where
// both are high. While instr_valid is high without instr_ready, instr,
// instr_pc (and instr_illegal) hold their values; only a redirect (flush)
// may withdraw instr_valid before the transfer.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [ILEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [ILEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [ILEN-1:0] redirect_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [ILEN-1:0] instr,
   output logic [ILEN-1:0] instr_pc,
   output logic [1:0]      dbg_state,
   output logic [1:0]      dbg_fifo_count
`ifdef FETCH_OPCODE_CHECK_EN
   ,
   output logic            instr_illegal
`endif
);

`ifdef FETCH_OPCODE_CHECK_EN
   localparam int ENTRY_W = 2 * ILEN + 1;
`else
   localparam int ENTRY_W = 2 * ILEN;
`endif

   fetch_state_t     r_state;
   logic [ILEN-1:0]  r_pc;
   logic [ILEN-1:0]  r_req_addr;

   logic             w_outstanding;
   logic [2:0]       w_occupancy;
   logic             w_issue;
   logic             w_push;
   logic             w_pop;
   logic             w_flush;
   logic [1:0]       w_count;
   logic [ENTRY_W-1:0] w_push_data;
   logic [ENTRY_W-1:0] w_head;
   logic [ILEN-1:0]  w_redirect_pc;
   logic             w_unused_redirect_lsbs;

   // Redirect targets are always word aligned.
   always_comb begin
      w_redirect_pc          = {redirect_pc[ILEN-1:2], 2'b00};
      w_unused_redirect_lsbs = ^redirect_pc[1:0];
   end

   // Issue decision: only from FETCH, only with room for the response once
   // it lands, and never in a redirect cycle.
   always_comb begin
      w_outstanding = (r_state != FETCH);
      w_occupancy   = {1'b0, w_count} + {2'b00, w_outstanding};
      w_issue       = (r_state == FETCH) && (w_occupancy < 3'd2) && !redirect_valid;
      imem_req      = w_issue && rst_n;
      imem_addr     = r_pc;
   end

   // Queue controls; a redirect flushes and suppresses both push and pop.
   always_comb begin
      w_flush = redirect_valid;
      w_push  = (r_state == WAIT) && imem_rvalid && !redirect_valid;
      w_pop   = instr_valid && instr_ready && !redirect_valid;
   end

   // Pack the queue entry as {instr, pc[, illegal]}.
   always_comb begin
`ifdef FETCH_OPCODE_CHECK_EN
      w_push_data = {imem_rdata, r_req_addr, ~is_supported_opcode(imem_rdata[6:0])};
`else
      w_push_data = {imem_rdata, r_req_addr};
`endif
   end

   // Fetch state machine, PC and address of the outstanding request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= FETCH;
         r_pc       <= RESET_PC;
         r_req_addr <= RESET_PC;
      end else if (redirect_valid) begin
         r_pc <= w_redirect_pc;
         case (r_state)
            // A response arriving alongside the redirect is stale; drop it
            // now, otherwise remember to drop the one still in flight.
            WAIT:    r_state <= imem_rvalid ? FETCH : DROP;
            // Still waiting on the stale response; if it arrives in this very
            // cycle it is consumed here, since no further response will come.
            DROP:    r_state <= imem_rvalid ? FETCH : DROP;
            default: r_state <= FETCH;
         endcase
      end else begin
         case (r_state)
            FETCH: begin
               if (w_issue) begin
                  r_req_addr <= r_pc;
                  r_pc       <= r_pc + 32'd4;
                  r_state    <= WAIT;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  r_state <= FETCH;
               end
            end
            DROP: begin
               if (imem_rvalid) begin
                  r_state <= FETCH;
               end
            end
            default: r_state <= FETCH;
         endcase
      end
   end

   fetch_fifo #(
      .W(ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .pop   (w_pop),
      .flush (w_flush),
      .din   (w_push_data),
      .count (w_count),
      .head  (w_head)
   );

   // Queue head drives the decoder-facing outputs directly.
   always_comb begin
      instr_valid    = (w_count != 2'd0);
      dbg_state      = r_state;
      dbg_fifo_count = w_count;
`ifdef FETCH_OPCODE_CHECK_EN
      instr          = w_head[ENTRY_W-1 -: ILEN];
      instr_pc       = w_head[ILEN:1];
      instr_illegal  = w_head[0];
`else
      instr          = w_head[ENTRY_W-1 -: ILEN];
      instr_pc       = w_head[ILEN-1:0];
`endif
   end

endmodule
